// File: rtl/id_stage_reg_if.sv
// ID/EX pipeline bundle: decoded fields entering the register and their registered copies.
interface id_stage_reg_if;
  logic        flush;
  logic        freeze;
  logic        valid_in;
  logic        WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in;
  logic [3:0]  EXE_CMD_in;
  logic [31:0] PC_in;
  logic [31:0] Val_Rn_in, Val_Rm_in;
  logic        imm_in;
  logic [11:0] Shift_operand_in;
  logic [23:0] Signed_imm_24_in;
  logic [3:0]  Dest_in, src1_in, src2_in;
  logic [3:0]  SR_in;

  logic        valid_out;
  logic        WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, B_out, S_out;
  logic [3:0]  EXE_CMD_out;
  logic [31:0] PC_out;
  logic [31:0] Val_Rn_out, Val_Rm_out;
  logic        imm_out;
  logic [11:0] Shift_operand_out;
  logic [23:0] Signed_imm_24_out;
  logic [3:0]  Dest_out, src1_out, src2_out;
  logic [3:0]  SR_out;

  modport master (
    output flush, freeze, valid_in,
    output WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in, EXE_CMD_in,
    output PC_in, Val_Rn_in, Val_Rm_in, imm_in, Shift_operand_in,
    output Signed_imm_24_in, Dest_in, src1_in, src2_in, SR_in,
    input  valid_out,
    input  WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, B_out, S_out, EXE_CMD_out,
    input  PC_out, Val_Rn_out, Val_Rm_out, imm_out, Shift_operand_out,
    input  Signed_imm_24_out, Dest_out, src1_out, src2_out, SR_out
  );

  modport slave (
    input  flush, freeze, valid_in,
    input  WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in, EXE_CMD_in,
    input  PC_in, Val_Rn_in, Val_Rm_in, imm_in, Shift_operand_in,
    input  Signed_imm_24_in, Dest_in, src1_in, src2_in, SR_in,
    output valid_out,
    output WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, B_out, S_out, EXE_CMD_out,
    output PC_out, Val_Rn_out, Val_Rm_out, imm_out, Shift_operand_out,
    output Signed_imm_24_out, Dest_out, src1_out, src2_out, SR_out
  );
endinterface

// File: rtl/id_stage_reg.sv
// ID/EX pipeline register with flush (squash), freeze (stall) and bubble handling.
// Every output is a flop; control bits are forced to zero for squashed or invalid entries.
module id_stage_reg #(
  parameter bit CLEAR_DATA_ON_FLUSH = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  id_stage_reg_if.slave bus
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.valid_out         <= 1'b0;
      bus.WB_EN_out         <= 1'b0;
      bus.MEM_R_EN_out      <= 1'b0;
      bus.MEM_W_EN_out      <= 1'b0;
      bus.B_out             <= 1'b0;
      bus.S_out             <= 1'b0;
      bus.EXE_CMD_out       <= 4'b0000;
      bus.PC_out            <= '0;
      bus.Val_Rn_out        <= '0;
      bus.Val_Rm_out        <= '0;
      bus.imm_out           <= 1'b0;
      bus.Shift_operand_out <= '0;
      bus.Signed_imm_24_out <= '0;
      bus.Dest_out          <= '0;
      bus.src1_out          <= '0;
      bus.src2_out          <= '0;
      bus.SR_out            <= '0;
    end else if (bus.flush) begin
      bus.valid_out    <= 1'b0;
      bus.WB_EN_out    <= 1'b0;
      bus.MEM_R_EN_out <= 1'b0;
      bus.MEM_W_EN_out <= 1'b0;
      bus.B_out        <= 1'b0;
      bus.S_out        <= 1'b0;
      bus.EXE_CMD_out  <= 4'b0000;
      // With the parameter clear, data fields simply keep their last value.
      if (CLEAR_DATA_ON_FLUSH) begin
        bus.PC_out            <= '0;
        bus.Val_Rn_out        <= '0;
        bus.Val_Rm_out        <= '0;
        bus.imm_out           <= 1'b0;
        bus.Shift_operand_out <= '0;
        bus.Signed_imm_24_out <= '0;
        bus.Dest_out          <= '0;
        bus.src1_out          <= '0;
        bus.src2_out          <= '0;
        bus.SR_out            <= '0;
      end
    end else if (!bus.freeze) begin
      // A bubble carries its data through but may not write or branch.
      bus.valid_out    <= bus.valid_in;
      bus.WB_EN_out    <= bus.valid_in & bus.WB_EN_in;
      bus.MEM_R_EN_out <= bus.valid_in & bus.MEM_R_EN_in;
      bus.MEM_W_EN_out <= bus.valid_in & bus.MEM_W_EN_in;
      bus.B_out        <= bus.valid_in & bus.B_in;
      bus.S_out        <= bus.valid_in & bus.S_in;
      bus.EXE_CMD_out  <= bus.valid_in ? bus.EXE_CMD_in : 4'b0000;
      bus.PC_out            <= bus.PC_in;
      bus.Val_Rn_out        <= bus.Val_Rn_in;
      bus.Val_Rm_out        <= bus.Val_Rm_in;
      bus.imm_out           <= bus.imm_in;
      bus.Shift_operand_out <= bus.Shift_operand_in;
      bus.Signed_imm_24_out <= bus.Signed_imm_24_in;
      bus.Dest_out          <= bus.Dest_in;
      bus.src1_out          <= bus.src1_in;
      bus.src2_out          <= bus.src2_in;
      bus.SR_out            <= bus.SR_in;
    end
  end

endmodule

// File: doc/id_stage_reg.md
ID_STAGE_REG -- requirements
Module: id_stage_reg

Interface
REQ-001 The block SHALL expose parameter CLEAR_DATA_ON_FLUSH, default 1: 1 = flush zeroes data fields too; 0 = flush zeroes control fields only and data fields hold.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with ports as listed:
  clk  in  1  rising-edge clock
  rst  in  1  asynchronous active-low reset (0 = reset)
  flush  in  1  branch taken; squash the entry being loaded
  freeze  in  1  hazard stall; hold all outputs
  valid_in  in  1  ID stage holds a real instruction
  WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in  in  1 each  control bits
  EXE_CMD_in  in  4  ALU command
  PC_in  in  32  PC of the instruction
  Val_Rn_in, Val_Rm_in  in  32 each  register-file read data
  imm_in  in  1  immediate-operand flag
  Shift_operand_in  in  12  shifter operand field
  Signed_imm_24_in  in  24  branch offset
  Dest_in, src1_in, src2_in  in  4 each  destination and source register numbers
  SR_in  in  4  status flags {N,Z,C,V}
  <name>_out  out  same width  registered copy of each <name>_in above
  valid_out  out  1  EX-stage entry is a real instruction

Function
REQ-003 All outputs SHALL be register outputs; no combinational path from any input to any output.
REQ-004 On a rising clk edge with rst=1, flush=0, freeze=0, every <name>_out SHALL take <name>_in and valid_out SHALL take valid_in (latency 1 cycle).
REQ-005 On a rising edge with flush=1, WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, B_out, S_out, valid_out SHALL become 0 and EXE_CMD_out SHALL become 4'b0000, regardless of freeze.
REQ-006 On flush with CLEAR_DATA_ON_FLUSH=1, all remaining outputs SHALL become 0; with CLEAR_DATA_ON_FLUSH=0, they SHALL hold.
REQ-007 On a rising edge with flush=0, freeze=1, all outputs SHALL hold their current values.
REQ-008 Priority SHALL be: rst > flush > freeze > load.
REQ-009 When valid_in=0 on a load edge, control outputs (REQ-005 list) SHALL be loaded as 0 irrespective of their inputs; data outputs SHALL load normally.
REQ-010 Widths SHALL pass through unchanged; no sign extension, truncation, or decoding of fields.
REQ-011 SR_out SHALL follow the same load/hold/flush rules as the other data fields.
REQ-012 A freeze held N cycles SHALL hold outputs N cycles; the first edge with freeze=0 SHALL load the then-present inputs.

Reset
REQ-013 While rst=0, all outputs SHALL be 0 immediately, without waiting for clk.
REQ-014 rst assertion mid-freeze or mid-flush SHALL override both; after rst deasserts, the first rising edge SHALL follow REQ-004..REQ-009.
REQ-015 rst deassertion SHALL be treated as synchronous to clk by the surrounding design; the block needs no internal synchronizer.

Verification
REQ-016 Reset: drive rst=0 between edges with outputs non-zero -> all outputs 0 before the next clk edge.
REQ-017 Load: valid_in=1, PC_in=32'h0000_0010, Val_Rm_in=32'hDEAD_BEEF, Shift_operand_in=12'h3E5, imm_in=0, WB_EN_in=1 -> one edge later, same values on outputs with valid_out=1.
REQ-018 Freeze: load PC_in=32'h20, then freeze=1 for 3 edges with PC_in=32'h24 -> PC_out stays 32'h20 for 3 edges, then becomes 32'h24 on the first edge with freeze=0.
REQ-019 Flush beats freeze: flush=1, freeze=1, MEM_W_EN_in=1, valid_in=1 -> MEM_W_EN_out=0, valid_out=0, EXE_CMD_out=0; data fields 0 (default parameter) or held (CLEAR_DATA_ON_FLUSH=0).
REQ-020 Bubble: valid_in=0 with WB_EN_in=1, S_in=1, Dest_in=4'hA -> WB_EN_out=0, S_out=0, valid_out=0, Dest_out=4'hA.
